// File: rtl/fnd_scan_capture_pkg.sv
// Shared definitions for the FND display path.
//   SEG_0..SEG_9, SEG_BLANK : 7-segment patterns {a..g}, active high (shared with the encoder)
//   NUM_BLANK, NUM_BAD      : codes the inverse decoder returns for blank / unknown patterns
//   ENB_BLANK               : digit-enable value with no digit selected
//   state_e                 : scan-capture FSM state encoding
//   enb_legal / enb_slot    : digit-enable classification helpers
package fnd_scan_capture_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h73;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] NUM_BLANK = 4'hA;
  localparam logic [3:0] NUM_BAD   = 4'hF;

  localparam logic [5:0] ENB_BLANK = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // Legal enable: exactly one active-low bit.
  function automatic logic enb_legal(input logic [5:0] enb);
    int unsigned zeros;
    zeros = 0;
    for (int unsigned k = 0; k < 6; k++) begin
      if (!enb[k]) zeros++;
    end
    return (zeros == 1);
  endfunction

  // Slot index of the active (low) enable bit; meaningful only for legal enables.
  function automatic logic [2:0] enb_slot(input logic [5:0] enb);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      if (!enb[k]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fnd_scan_capture_if.sv
// Multiplexed FND segment bus.
//   i_seg     [6:0] segments {a..g}, active high
//   i_seg_dp        decimal point of the current digit
//   i_seg_enb [5:0] digit enable, active low, one-hot-zero
// master: the display driver; slave: the scan capture.
interface fnd_scan_capture_if;
  logic [6:0] i_seg;
  logic       i_seg_dp;
  logic [5:0] i_seg_enb;

  modport master (output i_seg, i_seg_dp, i_seg_enb);
  modport slave  (input  i_seg, i_seg_dp, i_seg_enb);
endinterface

// File: rtl/fnd_inv_dec.sv
// Inverse FND decoder: 7-segment pattern back to a 4-bit digit code.
//   seg_i [6:0] segment pattern {a..g}
//   num_o [3:0] 0..9, NUM_BLANK for an all-off pattern, NUM_BAD otherwise
module fnd_inv_dec
  import fnd_scan_capture_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] num_o
);

  always_comb begin
    num_o = NUM_BAD;
    case (seg_i)
      SEG_0:     num_o = 4'd0;
      SEG_1:     num_o = 4'd1;
      SEG_2:     num_o = 4'd2;
      SEG_3:     num_o = 4'd3;
      SEG_4:     num_o = 4'd4;
      SEG_5:     num_o = 4'd5;
      SEG_6:     num_o = 4'd6;
      SEG_7:     num_o = 4'd7;
      SEG_8:     num_o = 4'd8;
      SEG_9:     num_o = 4'd9;
      SEG_BLANK: num_o = NUM_BLANK;
      default:   num_o = NUM_BAD;
    endcase
  end

endmodule

// File: rtl/fnd_scan_capture.sv
// Scan capture for a 6-digit multiplexed FND bus: rebuilds the full segment
// frame from the time-multiplexed {enb, seg, dp} bus.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus_if          : segment bus (slave modport)
//   o_six_digit_seg : last complete frame, slot k at [7k+6:7k]
//   o_six_dp        : last complete frame DP, slot k at bit k
//   o_num           : decoded digits, slot k at [4k+3:4k]
//   o_frame_vld     : one-cycle pulse when the frame outputs update
//   o_err           : sticky, illegal enable pattern seen
//   o_stall         : no enable change for TIMEOUT_CYC cycles
// Build option FND_DECODE_EN: when defined, o_num carries the inverse-decoded
// digits; otherwise o_num is constant all-ones and no decoder is built.
module fnd_scan_capture
  import fnd_scan_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic               clk,
  input  logic               rst_n,
  fnd_scan_capture_if.slave  bus_if,
  output logic [41:0]        o_six_digit_seg,
  output logic [5:0]         o_six_dp,
  output logic [23:0]        o_num,
  output logic               o_frame_vld,
  output logic               o_err,
  output logic               o_stall
);

  localparam int unsigned     SCW       = $clog2(SETTLE_CYC);
  localparam int unsigned     ICW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SCW-1:0]  STAB_LAST = SCW'(SETTLE_CYC - 2);
  localparam logic [ICW-1:0]  IDLE_MAX  = ICW'(TIMEOUT_CYC);
  localparam logic [ICW-1:0]  IDLE_PRE  = ICW'(TIMEOUT_CYC - 1);
  // Synchronisers start blank so reset release never looks like an illegal enable.
  localparam logic [13:0]     BUS_RST   = {ENB_BLANK, 8'h00};

  logic [13:0]      sync1_q, sync2_q, prev_q;
  state_e           state_q, state_d;
  logic [SCW-1:0]   stab_q, stab_d;
  logic [ICW-1:0]   idle_q, idle_d;
  logic [5:0]       mask_q, mask_d;
  logic [5:0][6:0]  shseg_q, shseg_d;
  logic [5:0]       shdp_q, shdp_d;
  logic [41:0]      oseg_q, oseg_d;
  logic [5:0]       odp_q, odp_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;

  logic [5:0]       bus_enb;
  logic [6:0]       bus_seg;
  logic             bus_dp;
  logic             enb_chg, bus_chg, capture;
  logic [2:0]       slot;

  assign {bus_enb, bus_seg, bus_dp} = sync2_q;
  assign enb_chg = (bus_enb != prev_q[13:8]);
  assign bus_chg = (sync2_q != prev_q);
  assign slot    = enb_slot(bus_enb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture fires on the edge where the counter would reach SETTLE_CYC-1.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enb_legal(bus_enb)) begin
          state_d = ST_SETTLE;
          stab_d  = '0;
        end
      end
      ST_SETTLE: begin
        if (enb_chg) begin
          stab_d = '0;
          if (!enb_legal(bus_enb)) state_d = ST_IDLE;
        end else if (bus_chg) begin
          stab_d = '0;
        end else if (stab_q == STAB_LAST) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (enb_chg) begin
          stab_d  = '0;
          state_d = enb_legal(bus_enb) ? ST_SETTLE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mask_d  = mask_q;
    shseg_d = shseg_q;
    shdp_d  = shdp_q;
    oseg_d  = oseg_q;
    odp_d   = odp_q;
    vld_d   = 1'b0;
    err_d   = err_q;
    idle_d  = idle_q;

    if (capture) begin
      shseg_d[slot] = bus_seg;
      shdp_d[slot]  = bus_dp;
      mask_d[slot]  = 1'b1;
      if (mask_d == '1) begin
        oseg_d = shseg_d;
        odp_d  = shdp_d;
        vld_d  = 1'b1;
        mask_d = '0;
      end
    end

    if (enb_chg)               idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;

    // Stall and illegal enables both abandon the partial frame.
    if (!enb_chg && (idle_q == IDLE_PRE)) mask_d = '0;
    if (enb_chg && !enb_legal(bus_enb) && (bus_enb != ENB_BLANK)) begin
      err_d  = 1'b1;
      mask_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= BUS_RST;
      sync2_q <= BUS_RST;
      prev_q  <= BUS_RST;
      stab_q  <= '0;
      idle_q  <= '0;
      mask_q  <= '0;
      shseg_q <= '0;
      shdp_q  <= '0;
      oseg_q  <= '0;
      odp_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= {bus_if.i_seg_enb, bus_if.i_seg, bus_if.i_seg_dp};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      stab_q  <= stab_d;
      idle_q  <= idle_d;
      mask_q  <= mask_d;
      shseg_q <= shseg_d;
      shdp_q  <= shdp_d;
      oseg_q  <= oseg_d;
      odp_q   <= odp_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

`ifdef FND_DECODE_EN
  logic [5:0][3:0] dec;
  logic [23:0]     num_q;

  for (genvar k = 0; k < 6; k++) begin : g_dec
    fnd_inv_dec u_dec (
      .seg_i (shseg_d[k]),
      .num_o (dec[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     num_q <= '1;
    else if (vld_d) num_q <= dec;
  end

  assign o_num = num_q;
`else
  assign o_num = '1;
`endif

  assign o_six_digit_seg = oseg_q;
  assign o_six_dp        = odp_q;
  assign o_frame_vld     = vld_q;
  assign o_err           = err_q;
  assign o_stall         = (idle_q == IDLE_MAX);

endmodule

// File: tb/tb_fnd_scan_capture.sv
module tb_fnd_scan_capture;

  localparam int unsigned SETTLE = 16;
  localparam int unsigned TOUT   = 20000;

  logic        clk;
  logic        rst_n;
  logic [41:0] o_seg;
  logic [5:0]  o_dp;
  logic [23:0] o_num;
  logic        o_vld, o_err, o_stall;

  fnd_scan_capture_if bus ();

  fnd_scan_capture #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TOUT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus_if          (bus),
    .o_six_digit_seg (o_seg),
    .o_six_dp        (o_dp),
    .o_num           (o_num),
    .o_frame_vld     (o_vld),
    .o_err           (o_err),
    .o_stall         (o_stall)
  );

  typedef struct packed {
    logic [41:0] seg;
    logic [5:0]  dp;
    logic [23:0] num;
  } frm_t;

  typedef struct {
    logic [5:0][6:0] seg;
    logic [5:0]      dp;
    logic [23:0]     num_dec;
    int unsigned     dwell;
    int unsigned     gap;
  } vec_t;

  vec_t vecs[4];
  frm_t sb[$];
  frm_t last_frm;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_frames = 0;
  logic saw_vld, saw_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic frm_t exp_frame(input vec_t v);
    frm_t f;
    f.seg = v.seg;
    f.dp  = v.dp;
`ifdef FND_DECODE_EN
    f.num = v.num_dec;
`else
    f.num = '1;
`endif
    return f;
  endfunction

  function automatic logic [5:0] enb_of(input int unsigned k);
    logic [5:0] oh;
    oh = 6'b1;
    oh = oh << k;
    return ~oh;
  endfunction

  // One clock cycle; outputs sampled at the falling edge, frames checked
  // against the scoreboard.
  task automatic tick();
    frm_t e;
    @(negedge clk);
    saw_vld   = o_vld;
    saw_stall = o_stall;
    if (rst_n && o_vld) begin
      n_frames++;
      chk("frame_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("frame_seg", 64'(o_seg), 64'(e.seg));
        chk("frame_dp",  64'(o_dp),  64'(e.dp));
        chk("frame_num", 64'(o_num), 64'(e.num));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] enb, input logic [6:0] seg, input logic dp,
                       input int unsigned cyc);
    bus.i_seg_enb = enb;
    bus.i_seg     = seg;
    bus.i_seg_dp  = dp;
    repeat (cyc) tick();
  endtask

  task automatic push_frame(input int vi);
    sb.push_back(exp_frame(vecs[vi]));
    last_frm = exp_frame(vecs[vi]);
  endtask

  task automatic scan(input int vi, input int unsigned first, input int unsigned cnt,
                      input bit push);
    int unsigned k;
    for (int unsigned i = 0; i < cnt; i++) begin
      k = (first + i) % 6;
      if (push && (i == cnt - 1)) push_frame(vi);
      drive(enb_of(k), vecs[vi].seg[k], vecs[vi].dp[k], vecs[vi].dwell);
      if (vecs[vi].gap != 0) drive(6'h3F, 7'h00, 1'b0, vecs[vi].gap);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_seg"},   64'(o_seg),   64'd0);
    chk({tag, "_dp"},    64'(o_dp),    64'd0);
    chk({tag, "_num"},   64'(o_num),   64'hFFFFFF);
    chk({tag, "_vld"},   64'(o_vld),   64'd0);
    chk({tag, "_err"},   64'(o_err),   64'd0);
    chk({tag, "_stall"}, 64'(o_stall), 64'd0);
  endtask

  initial begin
    int f0;
    int lat;
    bit got;

    vecs[0] = '{seg: {7'h00, 7'h00, 7'h79, 7'h6D, 7'h30, 7'h7E}, dp: 6'b000100,
                num_dec: 24'hAA3210, dwell: 5000, gap: 0};
    vecs[1] = '{seg: {7'h73, 7'h7F, 7'h70, 7'h5F, 7'h5B, 7'h33}, dp: 6'b101010,
                num_dec: 24'h987654, dwell: 40, gap: 0};
    vecs[2] = '{seg: {7'h5B, 7'h30, 7'h73, 7'h12, 7'h00, 7'h7F}, dp: 6'b010001,
                num_dec: 24'h519FA8, dwell: 40, gap: 10};
    vecs[3] = '{seg: {7'h7E, 7'h7E, 7'h7E, 7'h01, 7'h7E, 7'h7E}, dp: 6'b000000,
                num_dec: 24'h000F00, dwell: 40, gap: 0};

    rst_n         = 1'b0;
    bus.i_seg_enb = 6'h3F;
    bus.i_seg     = 7'h00;
    bus.i_seg_dp  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Full scans, one frame per six dwells.
    for (int i = 0; i < 4; i++) begin
      f0 = n_frames;
      scan(i, 0, 6, 1'b1);
      chk($sformatf("frames_per_scan%0d", i), 64'(n_frames - f0), 64'd1);
    end

    // Settle filter: five glitching cycles, then the real slot-5 value.
    scan(1, 0, 5, 1'b0);
    push_frame(1);
    bus.i_seg_enb = enb_of(5);
    bus.i_seg_dp  = vecs[1].dp[5];
    for (int g = 0; g < 5; g++) begin
      bus.i_seg = (g % 2 == 0) ? 7'h7F : 7'h01;
      tick();
    end
    bus.i_seg = vecs[1].seg[5];
    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      tick();
      lat++;
      if (saw_vld) got = 1'b1;
    end
    chk("settle_latency", 64'(lat - 1), 64'(SETTLE + 2));
    repeat (10) tick();

    // Illegal enable mid-frame.
    scan(2, 0, 3, 1'b0);
    drive(6'b111100, 7'h7E, 1'b0, 40);
    chk("err_set",  64'(o_err), 64'd1);
    chk("hold_seg", 64'(o_seg), 64'(last_frm.seg));
    chk("hold_dp",  64'(o_dp),  64'(last_frm.dp));
    chk("hold_num", 64'(o_num), 64'(last_frm.num));
    f0 = n_frames;
    scan(2, 3, 3, 1'b0);
    chk("no_frame_after_illegal", 64'(n_frames - f0), 64'd0);
    scan(2, 0, 3, 1'b1);
    chk("frame_after_illegal", 64'(n_frames - f0), 64'd1);
    chk("err_sticky", 64'(o_err), 64'd1);

    // Stall: slot 2 held past the timeout.
    scan(3, 0, 2, 1'b0);
    bus.i_seg_enb = enb_of(2);
    bus.i_seg     = vecs[3].seg[2];
    bus.i_seg_dp  = vecs[3].dp[2];
    repeat (TOUT + 3) tick();
    chk("stall_before_timeout", 64'(saw_stall), 64'd0);
    tick();
    chk("stall_at_timeout", 64'(saw_stall), 64'd1);
    bus.i_seg_enb = enb_of(3);
    bus.i_seg     = vecs[3].seg[3];
    bus.i_seg_dp  = vecs[3].dp[3];
    repeat (3) tick();
    chk("stall_until_change_seen", 64'(saw_stall), 64'd1);
    tick();
    chk("stall_cleared", 64'(saw_stall), 64'd0);
    repeat (vecs[3].dwell - 4) tick();
    f0 = n_frames;
    scan(3, 4, 2, 1'b0);
    chk("no_frame_after_stall", 64'(n_frames - f0), 64'd0);
    scan(3, 0, 3, 1'b1);
    chk("frame_after_stall", 64'(n_frames - f0), 64'd1);

    // Asynchronous reset after four captures.
    scan(1, 0, 4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    bus.i_seg_enb = 6'h3F;
    repeat (3) tick();
    rst_n = 1'b1;
    f0 = n_frames;
    scan(1, 4, 2, 1'b0);
    chk("no_frame_after_reset", 64'(n_frames - f0), 64'd0);
    scan(1, 0, 4, 1'b1);
    chk("frame_after_reset", 64'(n_frames - f0), 64'd1);

    repeat (20) tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("err_after_reset", 64'(o_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fnd_scan_capture.md
Name: fnd_scan_capture

Overview:
- Receive-side counterpart of the team's 6-digit multiplexed FND driver.
- Samples the time-multiplexed segment bus ({seg, dp, active-low one-hot digit enable}) and rebuilds the full 42-bit segment frame plus 6 DP bits.
- Optionally decodes each digit back to BCD.
- Used as an on-chip display monitor and as a bench checker for any display path.

Parameters:
- SETTLE_CYC, 16: consecutive stable clk cycles required before a digit is captured (min 2).
- TIMEOUT_CYC, 20000: clk cycles without any enable change before the scan is declared stalled.

Ports:
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  reset.
- i_seg  input  7  segment bus {a..g}, active high.
- i_seg_dp  input  1  decimal point of the current digit.
- i_seg_enb  input  6  digit enable, active low, one-hot-zero.
- o_six_digit_seg  output  42  last complete frame; slot k at [7k+6:7k].
- o_six_dp  output  6  last complete frame DP; slot k at bit k.
- o_num  output  24  decoded digits; slot k at [4k+3:4k].
- o_frame_vld  output  1  one-cycle pulse when the frame outputs update.
- o_err  output  1  sticky; illegal enable pattern seen.
- o_stall  output  1  scan stalled (timeout).

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clock is clk.
- Reset values:
  - All outputs 0, except o_num = 24'hFFFFFF.
  - Slot mask = 0, shadow registers = 0, FSM = IDLE.
- Input synchronisation: i_seg, i_seg_dp and i_seg_enb pass through 2-flop synchronisers. "Bus" below means the synchronised {enb, seg, dp}.
- Classification of enb:
  - Legal: exactly one bit 0.
  - Blank: 6'b111111.
  - Illegal: anything else.
- FSM states IDLE, SETTLE, HOLD:
  - IDLE: on a legal enb, go to SETTLE with stab_cnt = 0.
  - SETTLE:
    - stab_cnt increments on each edge where the bus equals its previous-cycle value.
    - Any bus change resets stab_cnt to 0.
    - When stab_cnt reaches SETTLE_CYC-1 with the bus still stable, capture on that edge: write seg/dp into the shadow slot of the low enb bit, set its mask bit, and go to HOLD.
  - HOLD: on an enb change, go to SETTLE (legal), IDLE (blank) or IDLE (illegal). A seg/dp change with the same enb is ignored.
- Capture latency: SETTLE_CYC+2 clk edges after a raw enb change, given a stable bus.
- Frame completion:
  - On the capture edge where the mask becomes 6'b111111, the shadow registers (including that capture) are copied to o_six_digit_seg, o_six_dp and o_num.
  - o_frame_vld is high for exactly the next cycle, and the mask clears.
  - Re-capturing an already-set slot before completion overwrites its shadow value and does not advance completion.
- Illegal enb: o_err is set (sticky until reset), the mask clears, and the FSM goes to IDLE. Frame outputs hold their values.
- Blank enb: the FSM goes to IDLE and the mask is retained, so blanking does not break a frame.
- Stall:
  - idle_cnt counts cycles since the last enb change and saturates at TIMEOUT_CYC.
  - When it reaches TIMEOUT_CYC, o_stall = 1 and the mask clears.
  - The next enb change clears o_stall and idle_cnt.
- Reset mid-frame: everything returns to reset values immediately. The first o_frame_vld after reset requires all six slots captured anew.

Optional Feature:
- Macro: FND_DECODE_EN.
- Defined: o_num slot k = inverse FND table:
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 73→9.
  - 00→4'hA (blank); any other pattern → 4'hF.
- Not defined: o_num is constant 24'hFFFFFF and the decoder logic is not instantiated.

Decomposition:
- Shared package holds:
  - FND segment constants SEG_0..SEG_9 and SEG_BLANK, shared with the encoder.
  - Decode codes NUM_BLANK = 4'hA and NUM_BAD = 4'hF.
  - FSM state encoding.
- One natural sub-module: fnd_inv_dec (7-bit pattern → 4-bit code, combinational), instantiated 6× under FND_DECODE_EN.

Test Plan:
- Normal scan:
  - Stimulus: driver model steps enb 111110→011111 with 5000-cycle dwell, slot patterns 7E,30,6D,79,00,00, dp = 6'b000100.
  - Response: o_frame_vld once per 6 dwells; o_six_digit_seg = {00,00,79,6D,30,7E}; o_six_dp = 04; o_num = 24'hAA3210 (decode on).
- Settle filter:
  - Stimulus: seg glitches for 5 cycles after an enb change.
  - Response: capture occurs SETTLE_CYC+2 cycles after the last glitch; the glitch value never appears.
- Illegal enable:
  - Stimulus: enb 111100 mid-frame.
  - Response: o_err = 1 and stays set; no o_frame_vld until 6 fresh captures; prior frame outputs unchanged.
- Stall:
  - Stimulus: enb held at 111011 for 20000 cycles.
  - Response: o_stall = 1 exactly at TIMEOUT_CYC.
  - Stimulus: resume scanning.
  - Response: o_stall = 0 on the first change; next frame requires 6 new captures.
- Blank / invalid patterns:
  - Stimulus: blank enb 111111 between digits.
  - Response: frame still completes.
  - Stimulus: pattern 7'h01 in slot 2.
  - Response: o_num[11:8] = F (decode on); o_num = FFFFFF (decode off).
- Async reset:
  - Stimulus: assert rst_n after 4 captures.
  - Response: outputs return to reset values in the same cycle; the first o_frame_vld after release comes after 6 full dwells.
